// File: rtl/pc_pcmux_interface.sv
// pc_pcmux_interface: RAT CPU program counter with its 4:1 next-address mux
//   CLK        rising-edge clock
//   RST        synchronous active-high reset of the PC
//   FROM_IMMED branch/call target from the instruction immediate
//   FROM_STACK return address from the stack
//   PC_MUX_SEL 0 immed, 1 stack, 2 ISR_VECTOR, 3 zero
//   PC_LD      load PC from DIN (beats PC_INC)
//   PC_INC     increment PC modulo 1024
//   PC_COUNT   registered PC, instruction memory address
//   DIN        combinational mux output
module pc_pcmux_interface #(
  parameter logic [9:0] ISR_VECTOR = 10'h3FF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [9:0] FROM_IMMED,
  input  logic [9:0] FROM_STACK,
  input  logic [1:0] PC_MUX_SEL,
  input  logic       PC_LD,
  input  logic       PC_INC,
  output logic [9:0] PC_COUNT,
  output logic [9:0] DIN
);
  logic [9:0] r_pc = 10'h000;
  logic [9:0] w_din;
  always_comb
    w_din = PC_MUX_SEL == 2'd0 ? FROM_IMMED :
            PC_MUX_SEL == 2'd1 ? FROM_STACK :
            PC_MUX_SEL == 2'd2 ? ISR_VECTOR : 10'h000;
  always_ff @(posedge CLK)
    r_pc <= RST ? 10'h000 : PC_LD ? w_din : PC_INC ? r_pc + 10'd1 : r_pc;
  assign DIN      = w_din;
  assign PC_COUNT = r_pc;
endmodule

// File: tb/tb_pc_pcmux_interface.sv
// tb_pc_pcmux_interface: randomized self-checking bench for pc_pcmux_interface
module tb_pc_pcmux_interface;
  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [9:0] FROM_IMMED = '0;
  logic [9:0] FROM_STACK = '0;
  logic [1:0] PC_MUX_SEL = '0;
  logic       PC_LD = 1'b0;
  logic       PC_INC = 1'b0;
  logic [9:0] PC_COUNT;
  logic [9:0] DIN;
  int checks = 0;
  int failures = 0;
  int m_pc = 0;
  pc_pcmux_interface dut (
    .CLK(CLK), .RST(RST), .FROM_IMMED(FROM_IMMED), .FROM_STACK(FROM_STACK),
    .PC_MUX_SEL(PC_MUX_SEL), .PC_LD(PC_LD), .PC_INC(PC_INC),
    .PC_COUNT(PC_COUNT), .DIN(DIN)
  );
  always #5 CLK = ~CLK;
  function automatic int ref_din(input int sel, input int imm, input int stk);
    int r;
    if (sel == 0) r = imm;
    else if (sel == 1) r = stk;
    else if (sel == 2) r = 1023;
    else r = 0;
    return r;
  endfunction
  task automatic tick();
    int d;
    d = ref_din(PC_MUX_SEL, FROM_IMMED, FROM_STACK);
    if (RST) m_pc = 0;
    else if (PC_LD) m_pc = d;
    else if (PC_INC) m_pc = (m_pc + 1) % 1024;
    @(posedge CLK);
    #1;
  endtask
  task automatic chk_pc(input string name);
    checks++;
    if (PC_COUNT !== 10'(m_pc)) begin
      failures++;
      $display("FAIL %s: PC_COUNT=%h expected=%h", name, PC_COUNT, 10'(m_pc));
    end
  endtask
  task automatic chk_din(input string name);
    int d;
    #1;
    d = ref_din(PC_MUX_SEL, FROM_IMMED, FROM_STACK);
    checks++;
    if (DIN !== 10'(d)) begin
      failures++;
      $display("FAIL %s: DIN=%h expected=%h", name, DIN, 10'(d));
    end
  endtask
  task automatic test_reset();
    #1;
    chk_pc("initial_value");
    RST = 1; PC_LD = 1; PC_INC = 1; FROM_IMMED = 10'h155;
    tick();
    chk_pc("reset_overrides");
    RST = 0; PC_LD = 0; PC_INC = 0;
  endtask
  task automatic test_idle();
    FROM_IMMED = 10'h00A; FROM_STACK = 10'h00B; PC_MUX_SEL = 0;
    chk_din("idle_din");
    tick();
    chk_pc("idle_hold");
  endtask
  task automatic test_load();
    PC_LD = 1; PC_MUX_SEL = 1;
    chk_din("load_din_stack");
    tick();
    chk_pc("load_stack");
    tick();
    chk_pc("load_stack_again");
    RST = 1; PC_LD = 0;
    tick();
    chk_pc("reset_from_b");
    PC_LD = 1;
    tick();
    RST = 1; PC_INC = 1;
    tick();
    chk_pc("reset_with_ld_inc");
    RST = 0; PC_LD = 0; PC_INC = 0;
  endtask
  task automatic test_increment();
    PC_INC = 1;
    tick();
    chk_pc("inc_1");
    tick();
    chk_pc("inc_2");
    PC_INC = 0;
    tick();
    chk_pc("inc_hold");
  endtask
  task automatic test_mux_priority();
    PC_MUX_SEL = 2;
    chk_din("din_isr");
    PC_MUX_SEL = 3;
    chk_din("din_zero");
    PC_MUX_SEL = 0; FROM_IMMED = 10'h123; PC_LD = 1; PC_INC = 1;
    chk_din("din_immed");
    tick();
    chk_pc("ld_over_inc");
    PC_LD = 0; PC_INC = 0;
  endtask
  task automatic test_wrap();
    PC_MUX_SEL = 2; PC_LD = 1;
    tick();
    chk_pc("load_isr");
    PC_LD = 0; PC_INC = 1;
    tick();
    chk_pc("wrap_zero");
    tick();
    chk_pc("wrap_one");
    PC_INC = 0;
  endtask
  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      RST = ($urandom_range(0, 15) == 0);
      PC_LD = ($urandom_range(0, 3) == 0);
      PC_INC = ($urandom_range(0, 1) == 1);
      PC_MUX_SEL = 2'($urandom_range(0, 3));
      FROM_IMMED = 10'($urandom);
      FROM_STACK = 10'($urandom);
      chk_din("rand_din");
      tick();
      chk_pc("rand_pc");
      FROM_IMMED = 10'($urandom);
      FROM_STACK = 10'($urandom);
      chk_din("rand_din_mid");
    end
    RST = 0; PC_LD = 0; PC_INC = 0;
  endtask
  initial begin
    test_reset();
    test_idle();
    test_load();
    test_increment();
    test_mux_priority();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
